// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module  : fetch_sequencer
// Brief   : PC owner and instruction-fetch sequencer (fetch, issue, redirect, halt)
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000,
  parameter int                PC_STEP      = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  // S_DROP is the single bubble cycle after a fetch discarded by a redirect.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_ISSUE  = 3'd2,
    S_DROP   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_VECTOR;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_d = redirect_addr;
        state_d = halt ? S_HALTED : S_REQ;
      end

      S_REQ: begin
        if (mem_ack) begin
          if (pend_q || redirect_valid) begin
            // A same-cycle redirect is the newest target, so it wins over the pending one.
            pc_d    = redirect_valid ? redirect_addr : pend_addr_q;
            pend_d  = 1'b0;
            state_d = S_DROP;
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + ADDR_W'(PC_STEP);
            state_d    = S_ISSUE;
          end
        end else if (redirect_valid) begin
          pend_d      = 1'b1;
          pend_addr_d = redirect_addr;
        end
      end

      S_ISSUE: begin
        if (redirect_valid) begin
          pc_d    = redirect_addr;
          state_d = S_REQ;
        end else if (instr_ready) begin
          state_d = halt ? S_HALTED : S_REQ;
        end
      end

      S_DROP: begin
        if (redirect_valid) pc_d = redirect_addr;
        state_d = S_REQ;
      end

      S_HALTED: begin
        if (redirect_valid) pc_d = redirect_addr;
        if (!halt) state_d = S_REQ;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req     = (state_q == S_REQ);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module  : tb_fetch_sequencer
// Brief   : Cycle-table bench for fetch_sequencer plus an async-reset sequence
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        halt;
  logic [15:0] pc;
  logic        halted;

  int checks;
  int failures;

  fetch_sequencer #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .RESET_VECTOR(16'h0000),
    .PC_STEP     (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .pc            (pc),
    .halted        (halted)
  );

  // Memory returns address XOR 5A5A, so every fetched word identifies its address.
  assign mem_rdata = mem_addr ^ 16'h5A5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        rdy;
    logic        rv;
    logic [15:0] raddr;
    logic        halt;
    logic        e_req;
    logic [15:0] e_pc;
    logic        e_vld;
    logic [15:0] e_instr;
    logic [15:0] e_ipc;
    logic        e_hlt;
  } vec_t;

  vec_t vecs[40];
  int   nvec;

  task automatic add(input logic r, input logic a, input logic rd, input logic rv,
                     input logic [15:0] ra, input logic h,
                     input logic er, input logic [15:0] ep, input logic ev,
                     input logic [15:0] ei, input logic [15:0] eip, input logic eh);
    vecs[nvec].rst     = r;
    vecs[nvec].ack     = a;
    vecs[nvec].rdy     = rd;
    vecs[nvec].rv      = rv;
    vecs[nvec].raddr   = ra;
    vecs[nvec].halt    = h;
    vecs[nvec].e_req   = er;
    vecs[nvec].e_pc    = ep;
    vecs[nvec].e_vld   = ev;
    vecs[nvec].e_instr = ei;
    vecs[nvec].e_ipc   = eip;
    vecs[nvec].e_hlt   = eh;
    nvec++;
  endtask

  task automatic check(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic check_outputs(input int row, input logic er, input logic [15:0] ep,
                               input logic ev, input logic [15:0] ei,
                               input logic [15:0] eip, input logic eh);
    check("mem_req",     row, 16'(mem_req),     16'(er));
    check("mem_addr",    row, mem_addr,         ep);
    check("pc",          row, pc,               ep);
    check("instr_valid", row, 16'(instr_valid), 16'(ev));
    check("instr",       row, instr,            ei);
    check("instr_pc",    row, instr_pc,         eip);
    check("halted",      row, 16'(halted),      16'(eh));
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    nvec           = 0;
    rst            = 1'b1;
    mem_ack        = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 16'h0000;
    halt           = 1'b0;

    //   rst ack rdy rv  raddr     halt | req pc        vld instr     ipc       hlt
    add(1, 0, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 16'h0000, 16'h0000, 0); // 0 reset
    add(0, 1, 1, 0, 16'h0000, 0,  0, 16'h0000, 0, 16'h0000, 16'h0000, 0); // 1 IDLE
    add(0, 1, 1, 0, 16'h0000, 0,  1, 16'h0000, 0, 16'h0000, 16'h0000, 0); // 2 REQ 0
    add(0, 1, 1, 0, 16'h0000, 0,  0, 16'h0001, 1, 16'h5A5A, 16'h0000, 0); // 3 ISSUE 0
    add(0, 1, 1, 0, 16'h0000, 0,  1, 16'h0001, 0, 16'h5A5A, 16'h0000, 0); // 4 REQ 1
    add(0, 1, 1, 0, 16'h0000, 0,  0, 16'h0002, 1, 16'h5A5B, 16'h0001, 0); // 5 ISSUE 1
    add(0, 1, 1, 0, 16'h0000, 0,  1, 16'h0002, 0, 16'h5A5B, 16'h0001, 0); // 6 REQ 2
    add(0, 0, 1, 1, 16'h0005, 0,  0, 16'h0003, 1, 16'h5A58, 16'h0002, 0); // 7 accept + redirect
    add(0, 0, 1, 0, 16'h0000, 0,  1, 16'h0005, 0, 16'h5A58, 16'h0002, 0); // 8 REQ 5 wait
    add(0, 0, 1, 0, 16'h0000, 0,  1, 16'h0005, 0, 16'h5A58, 16'h0002, 0); // 9
    add(0, 0, 1, 0, 16'h0000, 0,  1, 16'h0005, 0, 16'h5A58, 16'h0002, 0); // 10
    add(0, 1, 1, 0, 16'h0000, 0,  1, 16'h0005, 0, 16'h5A58, 16'h0002, 0); // 11 ack
    add(0, 0, 0, 0, 16'h0000, 0,  0, 16'h0006, 1, 16'h5A5F, 16'h0005, 0); // 12 hold
    add(0, 1, 0, 0, 16'h0000, 0,  0, 16'h0006, 1, 16'h5A5F, 16'h0005, 0); // 13 stray ack
    add(0, 0, 0, 1, 16'h0010, 0,  0, 16'h0006, 1, 16'h5A5F, 16'h0005, 0); // 14 drop + redirect
    add(0, 0, 0, 1, 16'h0030, 0,  1, 16'h0010, 0, 16'h5A5F, 16'h0005, 0); // 15 pending 0030
    add(0, 0, 0, 1, 16'h0040, 0,  1, 16'h0010, 0, 16'h5A5F, 16'h0005, 0); // 16 pending 0040
    add(0, 1, 0, 0, 16'h0000, 0,  1, 16'h0010, 0, 16'h5A5F, 16'h0005, 0); // 17 ack discarded
    add(0, 0, 0, 0, 16'h0000, 0,  0, 16'h0040, 0, 16'h5A5F, 16'h0005, 0); // 18 bubble
    add(0, 1, 0, 0, 16'h0000, 0,  1, 16'h0040, 0, 16'h5A5F, 16'h0005, 0); // 19 REQ 40
    add(0, 0, 1, 1, 16'h0080, 0,  0, 16'h0041, 1, 16'h5A1A, 16'h0040, 0); // 20 accept + redirect
    add(0, 1, 0, 1, 16'hFFFF, 0,  1, 16'h0080, 0, 16'h5A1A, 16'h0040, 0); // 21 redirect w/ ack
    add(0, 0, 0, 0, 16'h0000, 0,  0, 16'hFFFF, 0, 16'h5A1A, 16'h0040, 0); // 22 bubble
    add(0, 1, 0, 0, 16'h0000, 0,  1, 16'hFFFF, 0, 16'h5A1A, 16'h0040, 0); // 23 REQ FFFF
    add(0, 0, 1, 0, 16'h0000, 1,  0, 16'h0000, 1, 16'hA5A5, 16'hFFFF, 0); // 24 wrap, halt
    add(0, 0, 0, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'hA5A5, 16'hFFFF, 1); // 25 HALTED
    add(0, 0, 0, 1, 16'h0003, 1,  0, 16'h0000, 0, 16'hA5A5, 16'hFFFF, 1); // 26 redirect halted
    add(0, 0, 0, 0, 16'h0000, 0,  0, 16'h0003, 0, 16'hA5A5, 16'hFFFF, 1); // 27 release
    add(0, 0, 0, 0, 16'h0000, 1,  1, 16'h0003, 0, 16'hA5A5, 16'hFFFF, 0); // 28 halt in REQ
    add(0, 1, 0, 0, 16'h0000, 1,  1, 16'h0003, 0, 16'hA5A5, 16'hFFFF, 0); // 29 ack
    add(0, 0, 0, 0, 16'h0000, 1,  0, 16'h0004, 1, 16'h5A59, 16'h0003, 0); // 30 issue held
    add(0, 0, 1, 0, 16'h0000, 1,  0, 16'h0004, 1, 16'h5A59, 16'h0003, 0); // 31 handshake
    add(0, 0, 0, 0, 16'h0000, 0,  0, 16'h0004, 0, 16'h5A59, 16'h0003, 1); // 32 HALTED
    add(0, 0, 0, 0, 16'h0000, 0,  1, 16'h0004, 0, 16'h5A59, 16'h0003, 0); // 33 resume at 4

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      mem_ack        = vecs[i].ack;
      instr_ready    = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_addr  = vecs[i].raddr;
      halt           = vecs[i].halt;
      #1;
      check_outputs(i, vecs[i].e_req, vecs[i].e_pc, vecs[i].e_vld,
                    vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_hlt);
    end

    // Asynchronous reset in the middle of a REQ cycle, away from any clock edge.
    #1;
    rst = 1'b1;
    #1;
    check_outputs(100, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);

    // Leave reset with halt set: IDLE goes straight to HALTED.
    @(negedge clk);
    rst  = 1'b0;
    halt = 1'b1;
    mem_ack = 1'b0;
    #1;
    check_outputs(101, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    #1;
    check_outputs(102, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    halt = 1'b0;
    @(negedge clk);
    #1;
    check_outputs(103, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
